// File: rtl/fwd_scoreboard.sv
// Operand forwarding and hazard scoreboard for an ID/E/M/W pipeline.
// Resolves E-stage operands from M/W results and stalls ID on load-use or pending multi-cycle writes.
module fwd_scoreboard #(
  parameter int XLEN = 32,
  parameter int NSRC = 2,
  parameter int CNTW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 id_valid,
  input  logic [5*NSRC-1:0]    id_rs,
  input  logic [4:0]           id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_is_load,
  input  logic                 id_is_long,
  input  logic [XLEN*NSRC-1:0] e_rs_data,
  input  logic [XLEN-1:0]      m_data,
  input  logic [XLEN-1:0]      w_data,
  input  logic                 long_done,
  input  logic [4:0]           long_rd,
  output logic                 stall_id,
  output logic [2*NSRC-1:0]    fwd_sel,
  output logic [XLEN*NSRC-1:0] e_op_data,
  output logic [31:0]          busy,
  output logic [CNTW-1:0]      stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
  } tag_t;

  localparam tag_t            TAG_NONE = '{valid: 1'b0, rd: 5'd0, regwrite: 1'b0, is_load: 1'b0};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  tag_t                 e_tag_r;
  tag_t                 m_tag_r;
  tag_t                 w_tag_r;
  tag_t                 id_tag_s;
  logic [5*NSRC-1:0]    e_rs_r;
  logic [31:0]          busy_r;
  logic [31:0]          busy_set_s;
  logic [31:0]          busy_clr_s;
  logic [CNTW-1:0]      stall_cnt_r;
  logic                 hazard_s;
  logic                 stall_s;
  logic                 issue_s;
  logic [2*NSRC-1:0]    fwd_sel_s;
  logic [XLEN*NSRC-1:0] e_op_data_s;

  // allow_load=0 rejects a producer whose load data is not yet available
  function automatic logic tag_hit(input tag_t t, input logic [4:0] r, input logic allow_load);
    return t.valid && t.regwrite && (t.rd == r) && (r != 5'd0) && (allow_load || !t.is_load);
  endfunction

  // ID hazard detection plus scoreboard set/clear vectors
  always_comb begin
    hazard_s = id_regwrite && busy_r[id_rd];
    for (int i = 0; i < NSRC; i++) begin
      hazard_s = hazard_s
               || (e_tag_r.is_load && tag_hit(e_tag_r, id_rs[5*i +: 5], 1'b1))
               || busy_r[id_rs[5*i +: 5]];
    end
    stall_s  = id_valid && hazard_s;
    issue_s  = !hold && id_valid && !hazard_s;
    // Long ops write back outside the pipeline, so they never act as forwarding producers
    id_tag_s = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite && !id_is_long, is_load: id_is_load};
    busy_set_s = (issue_s && id_is_long && id_regwrite && (id_rd != 5'd0)) ? (32'd1 << id_rd) : 32'd0;
    busy_clr_s = long_done ? (32'd1 << long_rd) : 32'd0;
  end

  // E-stage operand selection, newest producer first
  always_comb begin
    fwd_sel_s   = {(2*NSRC){1'b0}};
    e_op_data_s = e_rs_data;
    for (int i = 0; i < NSRC; i++) begin
      if (tag_hit(m_tag_r, e_rs_r[5*i +: 5], 1'b0)) begin
        fwd_sel_s[2*i +: 2]         = 2'd1;
        e_op_data_s[XLEN*i +: XLEN] = m_data;
      end else if (tag_hit(w_tag_r, e_rs_r[5*i +: 5], 1'b1)) begin
        fwd_sel_s[2*i +: 2]         = 2'd2;
        e_op_data_s[XLEN*i +: XLEN] = w_data;
      end else begin
        fwd_sel_s[2*i +: 2]         = 2'd0;
        e_op_data_s[XLEN*i +: XLEN] = e_rs_data[XLEN*i +: XLEN];
      end
    end
  end

  // Pipeline tag shift; a stalled or empty ID slot enters E as a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      e_tag_r <= TAG_NONE;
      m_tag_r <= TAG_NONE;
      w_tag_r <= TAG_NONE;
      e_rs_r  <= {(5*NSRC){1'b0}};
    end else if (!hold) begin
      w_tag_r <= m_tag_r;
      m_tag_r <= e_tag_r;
      if (issue_s) begin
        e_tag_r <= id_tag_s;
        e_rs_r  <= id_rs;
      end else begin
        e_tag_r <= TAG_NONE;
        e_rs_r  <= {(5*NSRC){1'b0}};
      end
    end
  end

  // Long-op scoreboard; completions retire even while the pipeline is frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= ((busy_r & ~busy_clr_s) | busy_set_s) & 32'hFFFF_FFFE;
    end
  end

  // Saturating count of cycles where ID is held by a hazard
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNTW{1'b0}};
    end else if (stall_s && !hold && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end
  end

  assign stall_id  = stall_s;
  assign fwd_sel   = fwd_sel_s;
  assign e_op_data = e_op_data_s;
  assign busy      = busy_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter NSRC, default 2, number of source operands per instruction (1..3).
REQ-003 SHALL have parameter CNTW, default 32, width of stall statistics counter.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 hold  in  1  external pipeline freeze; no stage advances while high.
REQ-007 id_valid  in  1  instruction present in ID.
REQ-008 id_rs  in  5*NSRC  ID source register indices, source i at bits [5i+4:5i].
REQ-009 id_rd, id_regwrite, id_is_load, id_is_long  in  5,1,1,1  ID destination, write enable, load flag, multi-cycle-op flag.
REQ-010 e_rs_data  in  XLEN*NSRC  register-file read data for the instruction in E.
REQ-011 m_data, w_data  in  XLEN each  M-stage ALU result, W-stage writeback data.
REQ-012 long_done, long_rd  in  1,5  completion pulse and destination of a multi-cycle op.
REQ-013 stall_id  out  1  ID must hold; E receives a bubble.
REQ-014 fwd_sel  out  2*NSRC  per-source select: 0 regfile, 1 M, 2 W.
REQ-015 e_op_data  out  XLEN*NSRC  newest operand value per E source.
REQ-016 busy  out  32  scoreboard of pending multi-cycle destinations.
REQ-017 stall_cnt  out  CNTW  count of cycles with stall_id high.

Function
REQ-018 SHALL hold tag registers E, M, W, each {valid, rd, regwrite, is_load}, plus E source indices e_rs.
REQ-019 advance = ~hold; on advance: W<=M, M<=E, E<=ID fields if id_valid & ~stall_id, else E<=bubble (valid=0); on ~advance all tags hold.
REQ-020 A tag "writes r" iff valid & regwrite & rd==r & r!=0.
REQ-021 fwd_sel[i] SHALL be 1 if M writes e_rs[i] and M.is_load=0; else 2 if W writes e_rs[i]; else 0.
REQ-022 M SHALL take priority over W for the same register (newest value wins).
REQ-023 Source index 0 SHALL always select 0 (regfile) regardless of tags.
REQ-024 e_op_data[i] SHALL be combinational mux of e_rs_data[i]/m_data/w_data per fwd_sel[i]; zero-cycle latency.
REQ-025 Load-use hazard: stall_id=1 when id_valid and any id_rs[i]!=0 equals E.rd with E valid, regwrite, is_load.
REQ-026 Scoreboard hazard: stall_id=1 when id_valid and busy[id_rs[i]] for any i, or id_regwrite & busy[id_rd] (WAW).
REQ-027 stall_id SHALL be combinational and 0 when id_valid=0.
REQ-028 busy[id_rd] SHALL set on the edge the ID instruction moves to E with id_is_long & id_regwrite & id_rd!=0.
REQ-029 busy[long_rd] SHALL clear on any edge with long_done=1, independent of hold.
REQ-030 Set and clear of different registers in one cycle SHALL both take effect; same-register set+clear cannot occur (REQ-026), bench SHALL check this never arises.
REQ-031 busy[0] SHALL be constant 0.
REQ-032 A long op in E/M/W SHALL never drive forwarding (its regwrite tag treated as 0 downstream).
REQ-033 stall_cnt SHALL increment on every edge with stall_id=1 and hold=0, saturating at all-ones.

Reset
REQ-034 On rst edge: E, M, W valid=0, e_rs=0, busy=0, stall_cnt=0; rst overrides hold and long_done.
REQ-035 During/after reset: fwd_sel=0, e_op_data=e_rs_data, stall_id=0 until a hazard forms.
REQ-036 Reset mid-stall SHALL drop the stall next cycle and discard all pending scoreboard bits.

Verification
REQ-037 ALU chain: add x5 then use x5 next cycle, m_data=0x1234 -> fwd_sel=1, e_op_data=0x1234, no stall.
REQ-038 M/W priority: x7 written in M (0xAAAA) and W (0x5555), E reads x7 -> e_op_data=0xAAAA; with M bubble -> 0x5555.
REQ-039 Load-use: lw x3 in E, ID reads x3 -> stall_id=1 one cycle, E bubble, then fwd_sel=2 with w_data value; stall_cnt=1.
REQ-040 Long op: div x9 issues, busy[9]=1, dependent stalls 6 cycles until long_done,long_rd=9 -> busy[9]=0, stall drops next cycle, stall_cnt=6.
REQ-041 x0: M writes x0 with m_data=0xFFFF, E reads x0 -> fwd_sel=0, e_op_data=e_rs_data.
REQ-042 Reset during long-op stall with hold=1 -> busy=0, stall_cnt=0, stall_id=0 next cycle.
